// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding.
package serial_cmp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } cmp_state_t;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Start handshake, operand words and verdict outputs of the serial comparator.
// The master drives requests and operands; the slave is the comparator itself.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic             ready_out;
  logic [WIDTH-1:0] A_word_in;
  logic [WIDTH-1:0] B_word_in;
  logic             done_out;
  logic             is_greater;
  logic             is_equal;
  logic             is_less;

  modport master (
    output start_in, A_word_in, B_word_in,
    input  ready_out, done_out, is_greater, is_equal, is_less
  );

  modport slave (
    input  start_in, A_word_in, B_word_in,
    output ready_out, done_out, is_greater, is_equal, is_less
  );
endinterface

// File: rtl/comparator_one_bit.sv
// Single-bit unsigned comparator; purely combinational, zero latency.
// No flow control: outputs follow the inputs.
module comparator_one_bit (
  input  logic a,
  input  logic b,
  output logic greater,
  output logic equal,
  output logic less
);
  assign greater = a & ~b;
  assign equal   = ~(a ^ b);
  assign less    = ~a & b;
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned comparator, MSB first, stops on the first differing bit; done n+1 cycles after accept.
// Accepts start only in IDLE (ready_out); requests while busy are dropped, not queued.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] idx;
  logic             gt_q, eq_q, lt_q;
  logic             bit_gt, bit_eq, bit_lt;
  logic             accept;
  logic             last_bit;

  comparator_one_bit u_bit_cmp (
    .a       (a_sr[WIDTH-1]),
    .b       (b_sr[WIDTH-1]),
    .greater (bit_gt),
    .equal   (bit_eq),
    .less    (bit_lt)
  );

  assign accept   = bus.start_in && (state_q == IDLE);
  assign last_bit = (idx == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (bit_gt || bit_lt || (bit_eq && last_bit)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      idx     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sr <= bus.A_word_in;
            b_sr <= bus.B_word_in;
            idx  <= CNT_W'(WIDTH - 1);
            gt_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
          end
        end
        SHIFT: begin
          // Verdict bits are set only from the one-bit comparator outputs.
          if (bit_gt) begin
            gt_q <= 1'b1;
          end else if (bit_lt) begin
            lt_q <= 1'b1;
          end else if (bit_eq && last_bit) begin
            eq_q <= 1'b1;
          end else if (bit_eq) begin
            a_sr <= a_sr << 1;
            b_sr <= b_sr << 1;
            idx  <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_out  = (state_q == IDLE);
  assign bus.done_out   = (state_q == DONE);
  assign bus.is_greater = gt_q;
  assign bus.is_equal   = eq_q;
  assign bus.is_less    = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for the serial magnitude comparator: latency, verdicts, ignored starts, reset abort, back-to-back.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [2:0] v;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(8)) bus ();

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign v = {bus.is_greater, bus.is_equal, bus.is_less};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle and check every cycle up to and including done (cycle n+1).
  task automatic compare(input logic [7:0] a, input logic [7:0] b, input int n, input logic [2:0] exp_v);
    bus.A_word_in = a;
    bus.B_word_in = b;
    bus.start_in  = 1'b1;
    for (int cyc = 1; cyc <= n + 1; cyc++) begin
      @(negedge clk);
      chk("busy_ready", 32'(bus.ready_out), 32'd0);
      chk("done_timing", 32'(bus.done_out), 32'(cyc == n + 1));
      chk("verdict", 32'(v), (cyc == n + 1) ? 32'(exp_v) : 32'd0);
      bus.start_in  = 1'b0;
      bus.A_word_in = ~a;
      bus.B_word_in = ~b;
    end
  endtask

  task automatic hold(input int k, input logic [2:0] exp_v);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.ready_out), 32'd1);
      chk("idle_done", 32'(bus.done_out), 32'd0);
      chk("idle_verdict", 32'(v), 32'(exp_v));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_in  = 1'b0;
    bus.A_word_in = 8'h00;
    bus.B_word_in = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_out), 32'd1);
    chk("rst_done", 32'(bus.done_out), 32'd0);
    chk("rst_verdict", 32'(v), 32'd0);
    rst = 1'b0;
    hold(3, 3'b000);

    // MSB differs: minimum latency, verdict held afterwards
    compare(8'h80, 8'h7F, 1, 3'b100);
    hold(5, 3'b100);

    // LSB differs and fully equal: all 8 bits examined
    compare(8'h12, 8'h13, 8, 3'b001);
    hold(1, 3'b001);
    compare(8'hA5, 8'hA5, 8, 3'b010);
    hold(1, 3'b010);

    // Start pulsed again while busy must be ignored
    bus.A_word_in = 8'h40;
    bus.B_word_in = 8'h00;
    bus.start_in  = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      chk("ign_ready", 32'(bus.ready_out), 32'd0);
      chk("ign_done", 32'(bus.done_out), 32'(cyc == 3));
      chk("ign_verdict", 32'(v), (cyc == 3) ? 32'h4 : 32'd0);
      bus.A_word_in = 8'h00;
      bus.B_word_in = 8'hFF;
      bus.start_in  = (cyc < 3);
    end
    hold(6, 3'b100);

    // Reset in the middle of a compare aborts it without a done pulse
    bus.A_word_in = 8'h01;
    bus.B_word_in = 8'h00;
    bus.start_in  = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      chk("pre_abort_ready", 32'(bus.ready_out), 32'd0);
      chk("pre_abort_done", 32'(bus.done_out), 32'd0);
      chk("pre_abort_verdict", 32'(v), 32'd0);
      bus.start_in = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.ready_out), 32'd1);
    chk("abort_done", 32'(bus.done_out), 32'd0);
    chk("abort_verdict", 32'(v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(10, 3'b000);
    compare(8'h01, 8'h00, 8, 3'b100);
    hold(1, 3'b100);

    // Start held high: one compare every 3 cycles, verdicts alternate
    bus.A_word_in = 8'hF0;
    bus.B_word_in = 8'h0F;
    bus.start_in  = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      int ph;
      int p;
      logic [2:0] exp_v;
      @(negedge clk);
      ph    = cyc % 3;
      p     = (cyc - 1) / 3;
      exp_v = (p % 2 == 0) ? 3'b100 : 3'b001;
      chk("b2b_ready", 32'(bus.ready_out), 32'(ph == 0));
      chk("b2b_done", 32'(bus.done_out), 32'(ph == 2));
      chk("b2b_verdict", 32'(v), (ph == 1) ? 32'd0 : 32'(exp_v));
      if (ph == 1) begin
        bus.A_word_in = ((p + 1) % 2 == 0) ? 8'hF0 : 8'h0F;
        bus.B_word_in = ((p + 1) % 2 == 0) ? 8'h0F : 8'hF0;
      end
      if (cyc == 12) bus.start_in = 1'b0;
    end
    hold(2, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial WIDTH-bit unsigned magnitude comparator, built on the existing comparator_one_bit.
- Captures two words on a start handshake, then walks them MSB-first, one bit per clock, through a comparator_one_bit instance.
- Terminates on the first differing bit, or after the LSB.
- Reports a registered greater/equal/less verdict with a one-cycle done pulse; it is the downstream consumer of the one-bit comparator's outputs.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit-index counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start_in  input  1  request to compare; accepted only when ready_out=1.
- ready_out  output  1  high only in IDLE.
- A_word_in  input  WIDTH  operand A; sampled on the accepting edge only.
- B_word_in  input  WIDTH  operand B; sampled on the accepting edge only.
- done_out  output  1  one-cycle pulse; verdict valid from this cycle.
- is_greater  output  1  A > B (unsigned).
- is_equal  output  1  A == B.
- is_less  output  1  A < B.

Behaviour:
- Reset (async assert): state=IDLE, ready_out=1, done_out=0, is_greater=is_equal=is_less=0, shift registers and counter cleared. Deassertion is synchronised by the usual reset-release discipline.
- States: IDLE, SHIFT, DONE.
- IDLE, accepting edge (start_in && ready_out):
  - load a_sr<=A_word_in, b_sr<=B_word_in, idx<=WIDTH-1;
  - clear all three verdict outputs to 0;
  - go to SHIFT.
- IDLE, no accept: stay in IDLE; outputs hold the previous verdict.
- SHIFT: a_sr[WIDTH-1] and b_sr[WIDTH-1] drive the comparator_one_bit instance. Each cycle:
  - one-bit greater: register is_greater<=1, go to DONE.
  - one-bit less: register is_less<=1, go to DONE.
  - equal and idx==0: register is_equal<=1, go to DONE.
  - equal and idx>0: shift both registers left by 1, idx<=idx-1, stay in SHIFT.
- DONE: done_out=1 for exactly this cycle, then unconditionally return to IDLE.
- Latency:
  - Let the accepting edge be edge 0, and n the number of bits examined (n = WIDTH-i for a first mismatch at bit i, n = WIDTH if the words are equal).
  - done_out is high in the cycle following edge n, i.e. n+1 cycles after acceptance.
  - Minimum 2 cycles (MSB differs); maximum WIDTH+1.
- Verdict: exactly one of the three is 1 from done_out onward. The verdict holds through IDLE until the next accepted start clears it.
- start_in while in SHIFT or DONE (ready_out=0) is ignored and not queued. Operand changes after acceptance have no effect.
- Back-to-back: start_in held high re-accepts on the first IDLE cycle after DONE, so the throughput gap is one IDLE cycle.
- Reset mid-operation (SHIFT or DONE): immediate return to IDLE with all outputs at reset values; no done_out is produced for the aborted compare.
- WIDTH=1: the single SHIFT cycle always exits; done_out arrives exactly 2 cycles after acceptance.
- No X propagation: verdict registers are written only from the one-bit comparator result.

Decomposition:
- Package serial_cmp_pkg:
  - typedef enum logic [1:0] cmp_state_t {IDLE, SHIFT, DONE};
  - localparam encodings for the state values.
- Sub-module: one instance of comparator_one_bit, fed by the shift-register MSBs; its outputs are consumed combinationally by the FSM.
- All remaining logic (FSM, shift registers, counter, verdict registers) is flat in this module.

Test Plan:
- Reset, then idle 3 cycles -> ready_out=1, done_out=0, all verdicts 0 throughout.
- A=0x80, B=0x7F, start for 1 cycle -> ready_out=0 next cycle; done_out at cycle 2 with is_greater=1; verdict still held 5 cycles later.
- A=0x12, B=0x13 -> done_out at cycle 9 (all 8 bits examined), is_less=1; A=0xA5, B=0xA5 -> done_out at cycle 9, is_equal=1.
- A=0x40, B=0x00, then start_in pulsed again at cycles 1-2 with A=0x00, B=0xFF -> second request ignored; done_out at cycle 3, is_greater=1, exactly one done pulse.
- A=0x01, B=0x00, assert rst at cycle 4 -> outputs 0 the same cycle, no done_out, ready_out=1 after release; a new compare A=0x01, B=0x00 then yields is_greater at cycle 9.
- start_in held high with alternating operand pairs (0xF0/0x0F, 0x0F/0xF0) -> done pulses every 3 cycles with is_greater and is_less alternating; verdict cleared on each accept edge.
